// File: rtl/display_pkg.sv
// Shared types and constants for the digit history scanner.
// Holds the scan state encoding and scan period helper.
package display_pkg;

  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Cycles per digit, never below one.
  function automatic int scan_period(
    input int clk_hz,
    input int refresh_hz
  );
    int p;
    p = (refresh_hz > 0) ? clk_hz / refresh_hz : 1;
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low seven-segment pattern.
// Bit 0 is segment a, bit 6 is segment g.
module seg7_decoder (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Pure lookup, one pattern per nibble value.
  always_comb begin
    o_seg = 7'h7F;
    unique case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/digit_history_scanner.sv
// Four-deep counter history shown on a multiplexed display.
// Captures post-tick values, counts 15->0 wraps, scans digits.
module digit_history_scanner
  import display_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int REFRESH_HZ      = 100
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Tick,
  input  logic [3:0] CounterValue,
  input  logic       Freeze,
  output logic [6:0] Seg,
  output logic [3:0] DigitSel,
  output logic [3:0] WrapCount,
  output logic [3:0] Valid
);

  localparam int SCAN_PERIOD =
    scan_period(CLOCK_FREQUENCY, REFRESH_HZ);
  localparam logic [31:0] RELOAD = 32'(SCAN_PERIOD - 1);

  logic [3:0]  r_hist [4];
  logic [3:0]  r_valid;
  logic [3:0]  r_wrap;
  logic        r_tick_d;
  scan_state_t r_state;
  logic [31:0] r_pre;
  logic [6:0]  r_seg;
  logic [3:0]  r_dsel;

  logic        w_capture;
  logic        w_wrap;
  logic        w_pre_zero;
  logic [3:0]  w_sel_hex;
  logic        w_sel_valid;
  logic [6:0]  w_dec;

  assign w_capture   = r_tick_d & ~Freeze;
  assign w_wrap      = (CounterValue == 4'd0) &&
                       (r_hist[0] == 4'hF) && r_valid[0];
  assign w_pre_zero  = (r_pre == 32'd0);
  assign w_sel_hex   = r_hist[r_state];
  assign w_sel_valid = r_valid[r_state];

  seg7_decoder u_dec (
    .i_hex (w_sel_hex),
    .o_seg (w_dec)
  );

  // Delay Tick so the sample lands on the post-increment value.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) r_tick_d <= 1'b0;
    else        r_tick_d <= Tick;
  end

  // History shift register, fill flags and saturating wrap count.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      r_hist  <= '{default: 4'd0};
      r_valid <= 4'd0;
      r_wrap  <= 4'd0;
    end else if (w_capture) begin
      r_hist[3] <= r_hist[2];
      r_hist[2] <= r_hist[1];
      r_hist[1] <= r_hist[0];
      r_hist[0] <= CounterValue;
      r_valid   <= {r_valid[2:0], 1'b1};
      if (w_wrap && (r_wrap != 4'hF))
        r_wrap <= r_wrap + 4'd1;
    end
  end

  // Prescaler paces the digit scan state machine.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      r_pre   <= RELOAD;
      r_state <= SCAN_D0;
    end else if (w_pre_zero) begin
      r_pre <= RELOAD;
      unique case (r_state)
        SCAN_D0: r_state <= SCAN_D1;
        SCAN_D1: r_state <= SCAN_D2;
        SCAN_D2: r_state <= SCAN_D3;
        SCAN_D3: r_state <= SCAN_D0;
        default: r_state <= SCAN_D0;
      endcase
    end else begin
      r_pre <= r_pre - 32'd1;
    end
  end

  // Register display drive from the current digit and its slot.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      r_seg  <= SEG_BLANK;
      r_dsel <= 4'b1111;
    end else begin
      r_seg  <= w_sel_valid ? w_dec : SEG_BLANK;
      r_dsel <= ~(4'b0001 << r_state);
    end
  end

  assign Seg       = r_seg;
  assign DigitSel  = r_dsel;
  assign WrapCount = r_wrap;
  assign Valid     = r_valid;

endmodule

// File: tb/tb_digit_history_scanner.sv
// Self-checking bench for digit_history_scanner.
// Directed steps plus random ticks against a queue-based model.
module tb_digit_history_scanner;

  logic       clk;
  logic       Reset;
  logic       Tick;
  logic [3:0] CounterValue;
  logic       Freeze;
  logic [6:0] Seg;
  logic [3:0] DigitSel;
  logic [3:0] WrapCount;
  logic [3:0] Valid;

  int n_chk;
  int n_fail;

  int hist[$];
  int nvalid;
  int wraps;
  bit tickd;
  int k;

  logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  digit_history_scanner #(
    .CLOCK_FREQUENCY (500),
    .REFRESH_HZ      (100)
  ) dut (
    .ClockIn      (clk),
    .Reset        (Reset),
    .Tick         (Tick),
    .CounterValue (CounterValue),
    .Freeze       (Freeze),
    .Seg          (Seg),
    .DigitSel     (DigitSel),
    .WrapCount    (WrapCount),
    .Valid        (Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    nvalid = 0;
    wraps  = 0;
    tickd  = 1'b0;
    k      = 0;
  endtask

  // Starts and ends at a falling edge; one rising edge inside.
  task automatic cyc(
    input bit         t,
    input logic [3:0] v,
    input bit         f
  );
    int         sidx;
    logic [3:0] e_dsel;
    logic [6:0] e_seg;
    Tick         = t;
    CounterValue = v;
    Freeze       = f;
    sidx   = (k / 5) % 4;
    e_dsel = ~(4'b0001 << sidx);
    e_seg  = (sidx < nvalid) ? SEG_TAB[hist[sidx]] : 7'h7F;
    @(posedge clk);
    #1;
    if (tickd && !f) begin
      if (v == 0 && nvalid > 0 && hist[0] == 15 && wraps < 15)
        wraps++;
      hist.push_front(int'(v));
      if (hist.size() > 4) void'(hist.pop_back());
      if (nvalid < 4) nvalid++;
    end
    tickd = t;
    k++;
    chk("seg", 32'(Seg), 32'(e_seg));
    chk("dsel", 32'(DigitSel), 32'(e_dsel));
    chk("valid", 32'(Valid), 32'((1 << nvalid) - 1));
    chk("wrap", 32'(WrapCount), 32'(wraps));
    @(negedge clk);
  endtask

  initial begin
    int  guard;
    bit  hit;
    n_chk        = 0;
    n_fail       = 0;
    Reset        = 1'b0;
    Tick         = 1'b0;
    CounterValue = 4'd0;
    Freeze       = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_seg", 32'(Seg), 32'h7F);
    chk("rst_dsel", 32'(DigitSel), 32'hF);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_wrap", 32'(WrapCount), 32'h0);
    Reset = 1'b1;

    // Idle scan: all digits visited, display blank
    for (int i = 0; i < 25; i++) cyc(1'b0, 4'd0, 1'b0);

    // Single capture of 5
    cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b0, 4'd5, 1'b0);
    chk("one_valid", 32'(Valid), 32'h1);
    for (int i = 0; i < 22; i++) cyc(1'b0, 4'd5, 1'b0);

    // Back-to-back ticks 3 then 4
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b1, 4'd3, 1'b0);
    cyc(1'b0, 4'd4, 1'b0);
    chk("b2b_valid", 32'(Valid), 32'h7);
    chk("b2b_h0", 32'(hist[0]), 32'd4);
    for (int i = 0; i < 21; i++) cyc(1'b0, 4'd0, 1'b0);

    // Wraps: 15 then 0 repeated, saturating at 15
    cyc(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      cyc(i < 35, (i % 2 == 0) ? 4'd15 : 4'd0, 1'b0);
      if (i == 1) chk("wrap_first", 32'(WrapCount), 32'd1);
    end
    chk("wrap_sat", 32'(WrapCount), 32'd15);
    for (int i = 0; i < 21; i++) cyc(1'b0, 4'd0, 1'b0);

    // Freeze discards ticks, then one shift after release
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'd0, 1'b1);
      cyc(1'b0, 4'(7 + i), 1'b1);
    end
    chk("frz_valid", 32'(Valid), 32'hF);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'd9, 1'b1);
    cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    chk("frz_shift_h0", 32'(hist[0]), 32'd6);
    for (int i = 0; i < 21; i++) cyc(1'b0, 4'd0, 1'b0);

    // Random ticks, values and freeze
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 2) == 0,
          4'($urandom_range(0, 15)),
          $urandom_range(0, 3) == 0);

    // Asynchronous reset in SCAN_D2 with full history
    hit = 1'b0;
    for (guard = 0; guard < 200 && !hit; guard++) begin
      if (nvalid == 4 && ((k / 5) % 4) == 2 && (k % 5) == 2)
        hit = 1'b1;
      else
        cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    end
    chk("reach_d2", 32'(hit), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_seg", 32'(Seg), 32'h7F);
    chk("arst_dsel", 32'(DigitSel), 32'hF);
    chk("arst_wrap", 32'(WrapCount), 32'h0);
    chk("arst_valid", 32'(Valid), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold", 32'(DigitSel), 32'hF);
    @(negedge clk);
    Reset = 1'b1;
    model_reset();
    cyc(1'b0, 4'd0, 1'b0);
    chk("rel_dsel", 32'(DigitSel), 32'hE);
    chk("rel_seg", 32'(Seg), 32'h7F);
    for (int i = 0; i < 24; i++) cyc(1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
